// File: rtl/digit_entry_loader.sv
// digit_entry_loader: three-button editor for a six-digit display pattern.
// Raw keys are synchronized and debounced into one-cycle press events.
// The events edit a 24-bit buffer under a blinking cursor. A commit hands the
// buffer to the scroller through a valid/ready load port.
module digit_entry_loader #(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          BLINK_HALF      = 12_500_000,
    parameter logic [23:0] INIT_PATTERN    = 24'h067FFF
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        key_next_n,
    input  logic        key_inc_n,
    input  logic        key_commit_n,
    output logic [23:0] edit_pattern,
    output logic [5:0]  blank_mask,
    output logic [2:0]  cursor,
    output logic [23:0] load_data,
    output logic        load_valid,
    input  logic        load_ready,
    output logic        editing
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    // Key slot indices inside the packed key vectors.
    localparam int K_NEXT   = 0;
    localparam int K_INC    = 1;
    localparam int K_COMMIT = 2;

    typedef enum logic {ST_EDIT, ST_PENDING} state_t;

    // Digit increment: 0..8 count up, 9 goes to blank (F), blank and A..E go to 0.
    function automatic logic [3:0] inc_nibble(input logic [3:0] n);
        if (n <= 4'd8)      return n + 4'd1;
        else if (n == 4'd9) return 4'hF;
        else                return 4'h0;
    endfunction

    logic [2:0]      w_key_raw;
    logic [2:0]      r_sync1, r_sync2, r_stable, r_evt;
    logic [DB_W-1:0] r_db_cnt [3];

    state_t          r_state, w_state_next;
    logic [23:0]     r_pattern, w_pattern_next;
    logic [2:0]      r_cursor, w_cursor_next;
    logic [23:0]     r_load_data, w_load_data_next;
    logic            r_load_valid, w_load_valid_next;
    logic            w_blink_restart;
    logic [BL_W-1:0] r_blink_cnt, w_blink_cnt_next;
    logic            r_blink_off, w_blink_off_next;
    logic [5:0]      r_blank_mask, w_blank_mask_next;

    assign w_key_raw = {key_commit_n, key_inc_n, key_next_n};

    // Synchronize the raw keys and debounce them into press-event pulses.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            // NOTE: synchronizers and debouncers restart as released (1) so no
            // phantom press event fires when reset drops.
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_evt    <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_evt[i] <= 1'b0;
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_stable[i] <= r_sync2[i];
                    // Only the released->pressed transition is an event.
                    r_evt[i]    <= r_stable[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state logic for the edit/pending FSM and its datapath.
    always_comb begin
        // NOTE: every comb output gets a default first, so no latch is inferred.
        w_state_next      = r_state;
        w_pattern_next    = r_pattern;
        w_cursor_next     = r_cursor;
        w_load_data_next  = r_load_data;
        w_load_valid_next = r_load_valid;
        w_blink_restart   = 1'b0;
        case (r_state)
            ST_EDIT: begin
                if (r_evt[K_COMMIT]) begin
                    w_load_data_next  = r_pattern;
                    w_load_valid_next = 1'b1;
                    w_state_next      = ST_PENDING;
                end else if (r_evt[K_INC]) begin
                    for (int i = 0; i < 6; i++) begin
                        if (r_cursor == 3'(i))
                            w_pattern_next[i*4 +: 4] = inc_nibble(r_pattern[i*4 +: 4]);
                    end
                    w_blink_restart = 1'b1;
                end else if (r_evt[K_NEXT]) begin
                    w_cursor_next   = (r_cursor == 3'd0) ? 3'd5 : r_cursor - 3'd1;
                    w_blink_restart = 1'b1;
                end
            end
            ST_PENDING: begin
                // Key events are dropped here; only the handshake advances.
                if (r_load_valid && load_ready) begin
                    w_load_valid_next = 1'b0;
                    w_state_next      = ST_EDIT;
                end
            end
            default: w_state_next = ST_EDIT;
        endcase
    end

    // Next-state logic for the cursor blink and the registered blank mask.
    always_comb begin
        w_blink_cnt_next = r_blink_cnt + 1'b1;
        w_blink_off_next = r_blink_off;
        if (w_blink_restart) begin
            w_blink_cnt_next = '0;
            w_blink_off_next = 1'b0;
        end else if (r_blink_cnt == BL_LAST) begin
            w_blink_cnt_next = '0;
            w_blink_off_next = ~r_blink_off;
        end
        w_blank_mask_next = (w_state_next == ST_EDIT && w_blink_off_next)
                          ? (6'b1 << w_cursor_next) : 6'b0;
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= ST_EDIT;
            r_pattern    <= INIT_PATTERN;
            r_cursor     <= 3'd5;
            r_load_data  <= INIT_PATTERN;
            r_load_valid <= 1'b0;
            r_blink_cnt  <= '0;
            r_blink_off  <= 1'b0;
            r_blank_mask <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pattern    <= w_pattern_next;
            r_cursor     <= w_cursor_next;
            r_load_data  <= w_load_data_next;
            r_load_valid <= w_load_valid_next;
            r_blink_cnt  <= w_blink_cnt_next;
            r_blink_off  <= w_blink_off_next;
            r_blank_mask <= w_blank_mask_next;
        end
    end

    assign edit_pattern = r_pattern;
    assign cursor       = r_cursor;
    assign load_data    = r_load_data;
    assign load_valid   = r_load_valid;
    assign blank_mask   = r_blank_mask;
    assign editing      = (r_state == ST_EDIT);

endmodule

// File: tb/tb_digit_entry_loader.sv
// Testbench for digit_entry_loader with short debounce and blink periods.
module tb_digit_entry_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_next_n, key_inc_n, key_commit_n;
    logic [23:0] edit_pattern;
    logic [5:0]  blank_mask;
    logic [2:0]  cursor;
    logic [23:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic        editing;

    int n_pass  = 0;
    int n_total = 0;

    digit_entry_loader #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_HALF     (8),
        .INIT_PATTERN   (24'h067FFF)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .key_next_n  (key_next_n),
        .key_inc_n   (key_inc_n),
        .key_commit_n(key_commit_n),
        .edit_pattern(edit_pattern),
        .blank_mask  (blank_mask),
        .cursor      (cursor),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .editing     (editing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  keys;         // {commit, inc, next}, 1 = pressed
        logic [23:0] exp_pattern;
        logic [2:0]  exp_cursor;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Press the selected keys together, hold past debounce, then release fully.
    task automatic press(input logic [2:0] keys);
        key_next_n   = ~keys[0];
        key_inc_n    = ~keys[1];
        key_commit_n = ~keys[2];
        repeat (8) @(negedge clk);
        key_next_n   = 1'b1;
        key_inc_n    = 1'b1;
        key_commit_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        vecs[0]  = '{3'b001, 24'h167FFF, 3'd4};
        vecs[1]  = '{3'b001, 24'h167FFF, 3'd3};
        vecs[2]  = '{3'b010, 24'h168FFF, 3'd3};
        vecs[3]  = '{3'b010, 24'h169FFF, 3'd3};
        vecs[4]  = '{3'b010, 24'h16FFFF, 3'd3};  // 9 -> blank
        vecs[5]  = '{3'b010, 24'h160FFF, 3'd3};  // blank -> 0
        vecs[6]  = '{3'b001, 24'h160FFF, 3'd2};
        vecs[7]  = '{3'b010, 24'h1600FF, 3'd2};
        vecs[8]  = '{3'b010, 24'h1601FF, 3'd2};
        vecs[9]  = '{3'b001, 24'h1601FF, 3'd1};
        vecs[10] = '{3'b001, 24'h1601FF, 3'd0};
        vecs[11] = '{3'b001, 24'h1601FF, 3'd5};  // cursor wraps 0 -> 5
        vecs[12] = '{3'b010, 24'h2601FF, 3'd5};

        reset = 1'b1; key_next_n = 1'b1; key_inc_n = 1'b1; key_commit_n = 1'b1;
        load_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst pattern", 32'(edit_pattern), 32'h067FFF);
        check("rst cursor", 32'(cursor), 32'd5);
        check("rst valid/editing/blank", {load_valid, editing, blank_mask}, {1'b0, 1'b1, 6'b0});
        check("rst load_data", 32'(load_data), 32'h067FFF);

        // Bouncy inc press yields exactly one increment.
        key_inc_n = 1'b0; @(negedge clk);
        key_inc_n = 1'b1; @(negedge clk);
        key_inc_n = 1'b0; @(negedge clk);
        key_inc_n = 1'b1; @(negedge clk);
        key_inc_n = 1'b0; repeat (20) @(negedge clk);
        key_inc_n = 1'b1; repeat (10) @(negedge clk);
        check("bounce inc", 32'(edit_pattern), 32'h167FFF);

        // Table-driven edit sequence.
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].keys);
            check($sformatf("vec%0d pattern", i), 32'(edit_pattern), 32'(vecs[i].exp_pattern));
            check($sformatf("vec%0d cursor", i), 32'(cursor), 32'(vecs[i].exp_cursor));
        end

        // Blink at cursor 5: align to a rising mask, then measure both halves.
        n = 0;
        while (blank_mask != 6'b0 && n < 40) begin @(negedge clk); n++; end
        check("blink wait low", 32'(n < 40), 32'd1);
        n = 0;
        while (blank_mask == 6'b0 && n < 40) begin @(negedge clk); n++; end
        check("blink wait high", 32'(n < 40), 32'd1);
        check("blink mask", 32'(blank_mask), 32'b100000);
        n = 0;
        while (blank_mask != 6'b0 && n < 40) begin @(negedge clk); n++; end
        check("blink off length", 32'(n), 32'd8);
        n = 0;
        while (blank_mask == 6'b0 && n < 40) begin @(negedge clk); n++; end
        check("blink on length", 32'(n), 32'd8);

        // load_ready with nothing pending has no effect.
        load_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle ready", {load_valid, editing}, {1'b0, 1'b1});
        load_ready = 1'b0;

        // Commit held off by load_ready=0.
        press(3'b100);
        check("commit valid/editing", {load_valid, editing}, {1'b1, 1'b0});
        check("commit data", 32'(load_data), 32'h2601FF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d", i), {load_valid, blank_mask, load_data},
                  {1'b1, 6'b0, 24'h2601FF});
        end
        press(3'b010);
        press(3'b001);
        check("pending ignores keys", {cursor, edit_pattern}, {3'd5, 24'h2601FF});
        check("pending still valid", 32'(load_valid), 32'd1);
        load_ready = 1'b1;
        @(negedge clk);
        check("handshake done", {load_valid, editing}, {1'b0, 1'b1});
        check("handshake retains", {cursor, edit_pattern}, {3'd5, 24'h2601FF});
        load_ready = 1'b0;

        // Commit and inc in the same cycle: commit wins, inc dropped.
        press(3'b110);
        check("commit+inc valid", {load_valid, editing}, {1'b1, 1'b0});
        check("commit+inc pattern", 32'(edit_pattern), 32'h2601FF);
        check("commit+inc data", 32'(load_data), 32'h2601FF);

        // Reset in the middle of PENDING abandons the handshake.
        reset = 1'b1;
        @(negedge clk);
        check("rst pend valid/editing", {load_valid, editing}, {1'b0, 1'b1});
        check("rst pend pattern", 32'(edit_pattern), 32'h067FFF);
        check("rst pend cursor", 32'(cursor), 32'd5);
        reset = 1'b0;
        @(negedge clk);
        press(3'b010);
        check("post-reset inc", 32'(edit_pattern), 32'h167FFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
